// File: rtl/led_pkg.sv
// Shared constants and helpers for the LED arbiter slice.
package led_pkg;

  localparam int LED_W = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_OWN  = 2'd2;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: one-cycle tick pulse every CLK_HZ/TICK_HZ clocks.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int CLK_HZ  = 12000000,
  parameter int TICK_HZ = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = cnt_w(DIV);

  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic          tick_q, tick_d;

  // Wrap the prescaler at DIV-1 and pulse tick on the following cycle.
  always_comb begin
    tick_d    = (pre_cnt_q == PW'(DIV - 1));
    pre_cnt_d = tick_d ? '0 : pre_cnt_q + PW'(1);
  end

  // Prescaler state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      tick_q    <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/led_arbiter.sv
// Fixed-priority LED sharing with minimum hold, blink and global PWM dimming.
module led_arbiter
  import led_pkg::*;
#(
  parameter int CLK_HZ      = 12000000,
  parameter int TICK_HZ     = 1000,
  parameter int NREQ        = 4,
  parameter int HOLD_TICKS  = 100,
  parameter int BLINK_TICKS = 250,
  parameter int PWM_BITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [LED_W*NREQ-1:0] req_led,
  input  logic [NREQ-1:0]       req_blink,
  input  logic [PWM_BITS-1:0]   bright,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  tick,
  output logic [LED_W-1:0]      led
);

  localparam int HW = cnt_w(HOLD_TICKS);
  localparam int BW = cnt_w(BLINK_TICKS);

  logic                tick_w;
  logic [1:0]          state_q, state_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
  logic [LED_W-1:0]    pat_q, pat_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [LED_W-1:0]    led_q, led_d;
  logic                busy_q, busy_d;

  logic [NREQ-1:0]     prio_req;
  logic                owner_req;
  logic                higher_req;
  logic                rearb;
  logic [LED_W-1:0]    pat_sel;
  logic                blink_sel;
  logic                phase_ok;
  logic                pwm_on;

  led_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick_w)
  );

  // Priority encode requests and run the IDLE/HOLD/OWN grant FSM.
  always_comb begin
    // Isolate the lowest set bit: index 0 has highest priority.
    prio_req   = req & (~req + NREQ'(1));
    owner_req  = |(req & grant_q);
    // grant_q is one-hot in HOLD/OWN, so grant_q-1 masks every higher-priority index.
    higher_req = |(req & (grant_q - NREQ'(1)));
    state_d    = state_q;
    grant_d    = grant_q;
    hold_cnt_d = hold_cnt_q;
    rearb      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_d    = prio_req;
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end
      end
      ST_HOLD: begin
        if (tick_w) begin
          if (hold_cnt_q == HW'(HOLD_TICKS - 1)) begin
            rearb = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end
        end
      end
      ST_OWN: begin
        rearb = 1'b1;
      end
      default: begin
        state_d    = ST_IDLE;
        grant_d    = '0;
        hold_cnt_d = '0;
      end
    endcase

    // Hold expiry and OWN share one arbitration decision.
    if (rearb) begin
      if (higher_req) begin
        grant_d    = prio_req;
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
      end else if (owner_req) begin
        state_d = ST_OWN;
      end else if (|req) begin
        grant_d    = prio_req;
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
      end else begin
        grant_d    = '0;
        state_d    = ST_IDLE;
        hold_cnt_d = '0;
      end
    end
  end

  // Select the owner's pattern, run blink phase and PWM, and form the LED drive.
  always_comb begin
    pat_sel   = '0;
    blink_sel = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        pat_sel   = pat_sel | req_led[LED_W*i +: LED_W];
        blink_sel = blink_sel | req_blink[i];
      end
    end

    // pat_d feeds the LED directly so the LED follows the grant by one cycle.
    if (grant_q == '0) begin
      pat_d = '0;
    end else if (owner_req) begin
      pat_d = pat_sel;
    end else begin
      pat_d = pat_q;
    end

    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (grant_d != grant_q) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (tick_w) begin
      if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end

    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    pwm_on    = (&bright) | (pwm_cnt_q < bright);
    phase_ok  = ~blink_sel | phase_q;
    led_d     = pat_d & {LED_W{phase_ok}} & {LED_W{pwm_on}};
    busy_d    = |grant_d;
  end

  // Arbiter and LED output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      hold_cnt_q  <= '0;
      pat_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      pwm_cnt_q   <= '0;
      led_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      hold_cnt_q  <= hold_cnt_d;
      pat_q       <= pat_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      pwm_cnt_q   <= pwm_cnt_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign tick  = tick_w;
  assign led   = led_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Directed bench for led_arbiter: DIV=10, HOLD_TICKS=3, BLINK_TICKS=2, NREQ=4.
module tb_led_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [7:0] req_led = '0;
  logic [3:0] req_blink = '0;
  logic [3:0] bright = '0;
  logic [3:0] grant;
  logic       busy;
  logic       tick;
  logic [1:0] led;

  int checks = 0;
  int errors = 0;

  led_arbiter #(
    .CLK_HZ     (1000),
    .TICK_HZ    (100),
    .NREQ       (4),
    .HOLD_TICKS (3),
    .BLINK_TICKS(2),
    .PWM_BITS   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_led  (req_led),
    .req_blink(req_blink),
    .bright   (bright),
    .grant    (grant),
    .busy     (busy),
    .tick     (tick),
    .led      (led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Release lands on a negedge; the next posedge is edge 1.
  task automatic reset_dut();
    rst_n     = 1'b0;
    req       = '0;
    req_led   = '0;
    req_blink = '0;
    bright    = 4'hF;
    cyc(5);
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: reset values and tick cadence
    cyc(3);
    chk("rst_grant", 8'(grant), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_led", 8'(led), 8'h0);
    chk("rst_tick", 8'(tick), 8'h0);
    cyc(2);
    rst_n = 1'b1;
    chk("rel_grant", 8'(grant), 8'h0);
    chk("rel_led", 8'(led), 8'h0);
    for (int k = 1; k <= 30; k++) begin
      cyc(1);
      chk("tick", 8'(tick), 8'((k % 10) == 0));
    end

    // 2: single request, grant then LED latency
    reset_dut();
    req_led = 8'h31;
    cyc(2);
    req = 4'b0100;
    cyc(1);
    chk("t2_grant", 8'(grant), 8'h4);
    chk("t2_busy", 8'(busy), 8'h1);
    chk("t2_led_early", 8'(led), 8'h0);
    cyc(1);
    chk("t2_led", 8'(led), 8'h3);

    // 3: higher priority waits for hold expiry
    cyc(8);
    req = 4'b0101;
    cyc(8);
    chk("t3_grant_t2", 8'(grant), 8'h4);
    cyc(10);
    chk("t3_grant_pre", 8'(grant), 8'h4);
    cyc(1);
    chk("t3_grant_post", 8'(grant), 8'h1);
    chk("t3_led_old", 8'(led), 8'h3);
    cyc(1);
    chk("t3_led_new", 8'(led), 8'h1);

    // 4: owner drops during hold with nothing else pending
    reset_dut();
    req_led = 8'h30;
    cyc(2);
    req = 4'b0100;
    cyc(10);
    req = 4'b0000;
    cyc(18);
    chk("t4_grant_held", 8'(grant), 8'h4);
    chk("t4_led_latched", 8'(led), 8'h3);
    chk("t4_busy_held", 8'(busy), 8'h1);
    cyc(1);
    chk("t4_grant_idle", 8'(grant), 8'h0);
    chk("t4_busy_idle", 8'(busy), 8'h0);
    cyc(1);
    chk("t4_led_off", 8'(led), 8'h0);

    // OWN is preempted on the next edge by a higher priority request
    reset_dut();
    req_led = 8'h38;
    cyc(2);
    req = 4'b0100;
    cyc(29);
    chk("own_grant", 8'(grant), 8'h4);
    cyc(4);
    req = 4'b0110;
    cyc(1);
    chk("own_preempt", 8'(grant), 8'h2);
    cyc(1);
    chk("own_preempt_led", 8'(led), 8'h2);

    // 5: blink, 20-cycle half-periods starting ON at grant
    reset_dut();
    req_led   = 8'h30;
    req_blink = 4'b0100;
    cyc(2);
    req = 4'b0100;
    cyc(2);
    chk("t5_on0", 8'(led), 8'h3);
    cyc(17);
    chk("t5_on_end", 8'(led), 8'h3);
    cyc(1);
    chk("t5_off0", 8'(led), 8'h0);
    cyc(19);
    chk("t5_off_end", 8'(led), 8'h0);
    cyc(1);
    chk("t5_on1", 8'(led), 8'h3);
    cyc(19);
    chk("t5_on1_end", 8'(led), 8'h3);
    cyc(1);
    chk("t5_off1", 8'(led), 8'h0);

    // 6: PWM duty 4/16, then brightness 0
    reset_dut();
    bright  = 4'h4;
    req_led = 8'h30;
    cyc(2);
    req = 4'b0100;
    cyc(1);
    for (int k = 4; k <= 35; k++) begin
      cyc(1);
      chk("pwm4", 8'(led), 8'((((k - 1) % 16) < 4) ? 3 : 0));
    end
    bright = 4'h0;
    for (int k = 0; k < 16; k++) begin
      cyc(1);
      chk("pwm0", 8'(led), 8'h0);
    end

    // Asynchronous reset in the middle of HOLD
    reset_dut();
    req_led = 8'h30;
    cyc(2);
    req = 4'b0100;
    cyc(8);
    chk("ar_grant_before", 8'(grant), 8'h4);
    chk("ar_led_before", 8'(led), 8'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_grant", 8'(grant), 8'h0);
    chk("ar_busy", 8'(busy), 8'h0);
    chk("ar_led", 8'(led), 8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
